// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: mode encodings and mode width.
package led_pkg;

  localparam int LED_MODE_W = 3;

  typedef enum logic [LED_MODE_W-1:0] {
    LED_MODE_OFF     = 3'd0,
    LED_MODE_ON      = 3'd1,
    LED_MODE_BLINK   = 3'd2,
    LED_MODE_CHASE   = 3'd3,
    LED_MODE_BOUNCE  = 3'd4,
    LED_MODE_BREATHE = 3'd5,
    LED_MODE_BINARY  = 3'd6,
    LED_MODE_RSVD    = 3'd7
  } led_mode_e;

endpackage

// File: rtl/led_prescaler.sv
// Programmable prescaler: wraps every div_max+1 cycles and emits a one-cycle tick.
// step is the combinational wrap condition, so consumers advance on the same edge tick rises.
module led_prescaler #(
  parameter int DIV_WIDTH = 26
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 restart,
  input  logic [DIV_WIDTH-1:0] div_max,
  output logic                 step,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] div_cnt;

  // A restart suppresses a coinciding wrap; the counter simply rolls over
  // if div_max is lowered beneath it.
  assign step = (div_cnt == div_max) && !restart;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (step) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-pattern LED driver: one prescaler, runtime-selected pattern, registered LED outputs.
// Pattern state changes on the wrap edge; led reflects it one edge later.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_LEDS  = 4,
  parameter int DIV_WIDTH = 26,
  parameter int PWM_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LED_MODE_W-1:0] mode,
  input  logic [DIV_WIDTH-1:0]  div_max,
  output logic [NUM_LEDS-1:0]   led,
  output logic                  tick
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [NUM_LEDS-1:0] POS_INIT = NUM_LEDS'(1);

  led_mode_e           mode_q;
  logic                restart;
  logic                step;

  logic                blink_q, blink_d;
  logic [NUM_LEDS-1:0] pos_q, pos_d;
  logic                bdir_dn_q, bdir_dn_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                ramp_dn_q, ramp_dn_d;
  logic [NUM_LEDS-1:0] bin_q, bin_d;
  logic [PWM_BITS-1:0] pwm_q;
  logic [NUM_LEDS-1:0] led_d;

  assign restart = (mode != mode_q);

  led_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .div_max (div_max),
    .step    (step),
    .tick    (tick)
  );

  always_comb begin
    blink_d   = blink_q;
    pos_d     = pos_q;
    bdir_dn_d = bdir_dn_q;
    duty_d    = duty_q;
    ramp_dn_d = ramp_dn_q;
    bin_d     = bin_q;
    if (restart) begin
      blink_d   = 1'b0;
      pos_d     = POS_INIT;
      bdir_dn_d = 1'b0;
      duty_d    = '0;
      ramp_dn_d = 1'b0;
      bin_d     = '0;
    end else if (step) begin
      blink_d = ~blink_q;
      bin_d   = bin_q + 1'b1;
      case (mode_q)
        LED_MODE_CHASE: pos_d = (pos_q << 1) | (pos_q >> (NUM_LEDS - 1));
        LED_MODE_BOUNCE: begin
          // A single LED has nowhere to move, so it just stays lit.
          if (NUM_LEDS > 1) begin
            if (!bdir_dn_q) begin
              if (pos_q[NUM_LEDS-1]) begin
                pos_d     = pos_q >> 1;
                bdir_dn_d = 1'b1;
              end else begin
                pos_d = pos_q << 1;
              end
            end else begin
              if (pos_q[0]) begin
                pos_d     = pos_q << 1;
                bdir_dn_d = 1'b0;
              end else begin
                pos_d = pos_q >> 1;
              end
            end
          end
        end
        default: ;
      endcase
      // Triangle ramp that turns around without repeating the endpoint.
      if (!ramp_dn_q) begin
        if (duty_q == DUTY_MAX) begin
          duty_d    = duty_q - 1'b1;
          ramp_dn_d = 1'b1;
        end else begin
          duty_d = duty_q + 1'b1;
        end
      end else begin
        if (duty_q == '0) begin
          duty_d    = duty_q + 1'b1;
          ramp_dn_d = 1'b0;
        end else begin
          duty_d = duty_q - 1'b1;
        end
      end
    end
  end

  always_comb begin
    led_d = '0;
    case (mode_q)
      LED_MODE_ON:      led_d = '1;
      LED_MODE_BLINK:   led_d = {NUM_LEDS{blink_q}};
      LED_MODE_CHASE:   led_d = pos_q;
      LED_MODE_BOUNCE:  led_d = pos_q;
      LED_MODE_BREATHE: led_d = {NUM_LEDS{pwm_q < duty_q}};
      LED_MODE_BINARY:  led_d = bin_q;
      default:          led_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= LED_MODE_OFF;
      blink_q   <= 1'b0;
      pos_q     <= POS_INIT;
      bdir_dn_q <= 1'b0;
      duty_q    <= '0;
      ramp_dn_q <= 1'b0;
      bin_q     <= '0;
      pwm_q     <= '0;
      led       <= '0;
    end else begin
      mode_q    <= led_mode_e'(mode);
      blink_q   <= blink_d;
      pos_q     <= pos_d;
      bdir_dn_q <= bdir_dn_d;
      duty_q    <= duty_d;
      ramp_dn_q <= ramp_dn_d;
      bin_q     <= bin_d;
      pwm_q     <= pwm_q + 1'b1;
      led       <= led_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: a vector table for reset/prescaler/blink/chase/bounce,
// then hand-written sequences for breathe windows, binary wrap and mid-run mode switches.
module tb_led_pattern_gen;

  localparam int NL = 4;
  localparam int DW = 8;
  localparam int PB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    mode;
  logic [DW-1:0] div_max;
  logic [NL-1:0] led;
  logic          tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          rst;
    logic [2:0]    mode;
    logic [DW-1:0] div_max;
    logic [NL-1:0] exp_led;
    logic          exp_tick;
  } vec_t;

  vec_t           vecs[$];
  logic [NL:0]    exp_q[$];

  led_pattern_gen #(.NUM_LEDS(NL), .DIV_WIDTH(DW), .PWM_BITS(PB)) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .div_max (div_max),
    .led     (led),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [2:0] m, input logic [DW-1:0] dm,
                              input logic [NL-1:0] el, input logic et);
    vec_t v;
    v.rst = r; v.mode = m; v.div_max = dm; v.exp_led = el; v.exp_tick = et;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [NL-1:0] bseq [9];
    logic [NL:0]   exp;
    int            hi;
    int            duty;

    rst = 1'b1; mode = 3'd0; div_max = 8'd3;
    bseq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4};

    // reset held two cycles, then OFF with period-4 ticks
    add(1, 0, 3, 4'h0, 0);
    add(1, 0, 3, 4'h0, 0);
    for (int k = 1; k <= 12; k++) add(0, 0, 3, 4'h0, (k % 4) == 0);
    // BLINK: restart, ticks at k=5,9,13, led toggles one cycle later
    for (int k = 1; k <= 13; k++)
      add(0, 2, 3, (k < 6) ? 4'h0 : ((((k - 6) / 4) % 2) == 0 ? 4'hF : 4'h0),
          (k >= 5) && (((k - 1) % 4) == 0));
    // CHASE at div_max=0: restart shows last blink state, then rotate every cycle
    add(0, 3, 0, 4'hF, 0);
    for (int k = 2; k <= 7; k++) add(0, 3, 0, NL'(1 << ((k - 2) % 4)), 1);
    // BOUNCE: restart shows last chase position, then bounces between the ends
    add(0, 4, 0, 4'h4, 0);
    for (int k = 2; k <= 10; k++) add(0, 4, 0, bseq[k-2], 1);
    // reset mid-bounce, then the mode difference from OFF forces a restart
    add(1, 4, 0, 4'h0, 0);
    add(0, 4, 0, 4'h0, 0);
    add(0, 4, 0, 4'h1, 1);

    foreach (vecs[i]) exp_q.push_back({vecs[i].exp_tick, vecs[i].exp_led});
    foreach (vecs[i]) begin
      rst = vecs[i].rst; mode = vecs[i].mode; div_max = vecs[i].div_max;
      step();
      exp = exp_q.pop_front();
      check($sformatf("vec%0d_led", i), 32'(led), 32'(exp[NL-1:0]));
      check($sformatf("vec%0d_tick", i), 32'(tick), 32'(exp[NL]));
    end

    // BREATHE: duty d holds for an 8-cycle window; led high d cycles in it
    mode = 3'd5; div_max = 8'd7;
    step();
    check("breathe_restart_led", 32'(led), 32'h2);
    check("breathe_restart_tick", 32'(tick), 32'h0);
    for (int w = 0; w <= 15; w++) begin
      duty = (w <= 7) ? w : ((w <= 14) ? 14 - w : 1);
      hi = 0;
      for (int j = 0; j < 8; j++) begin
        step();
        check($sformatf("breathe_uniform_w%0d", w), 32'((led == 4'h0) || (led == 4'hF)), 32'h1);
        check($sformatf("breathe_tick_w%0d_j%0d", w, j), 32'(tick), 32'(j == 7));
        hi += int'(led[0]);
      end
      check($sformatf("breathe_high_count_w%0d", w), 32'(hi), 32'(duty));
    end

    // BINARY at div_max=1: count 0..15 then wrap to 0
    mode = 3'd6; div_max = 8'd1;
    step();
    check("binary_restart_tick", 32'(tick), 32'h0);
    for (int k = 2; k <= 35; k++) begin
      step();
      check($sformatf("binary_led_k%0d", k), 32'(led), 32'(((k - 2) / 2) % 16));
      check($sformatf("binary_tick_k%0d", k), 32'(tick), 32'((k % 2) == 1));
    end

    // switch to ON while tick is high: restart drops the tick and reloads div_cnt
    mode = 3'd1;
    step();
    check("on_switch_led0", 32'(led), 32'h1);
    check("on_switch_tick0", 32'(tick), 32'h0);
    step();
    check("on_switch_led1", 32'(led), 32'hF);
    check("on_switch_tick1", 32'(tick), 32'h0);
    step();
    check("on_switch_led2", 32'(led), 32'hF);
    check("on_switch_tick2", 32'(tick), 32'h1);

    // reserved mode behaves as OFF
    mode = 3'd7;
    step();
    check("rsvd_led0", 32'(led), 32'hF);
    step();
    check("rsvd_led1", 32'(led), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
